// File: rtl/core_pcau.sv
// Program counter update unit: absolute load, signed relative add, or hold.
// Optional macro PCAU_PHASE_GATE_EN restricts updates to every other memory-clock edge.
module core_pcau (
  input  logic        pcau_clock_mem_i,
  input  logic        pcau_reset_i_b,
  input  logic [7:0]  pcau_offset_i,
  input  logic        pcau_en_i,
  input  logic        pcau_pc_direct_i,
  input  logic [7:0]  pcau_pc_msb_i,
  input  logic [2:0]  pcau_fsm_state_i,
  output logic [15:0] pcau_pc_o
);

  localparam logic [2:0] FsmIdle = 3'd0;

  logic [15:0] pc_d, pc_q;
  logic [15:0] offset_ext;
  logic        upd_ok;

`ifdef PCAU_PHASE_GATE_EN
  logic phase_d, phase_q;

  // The memory clock runs at twice the FSM rate; phase 0 marks the one
  // edge per FSM cycle on which the PC may move.
  always_comb begin
    phase_d = ~phase_q;
    upd_ok  = ~phase_q;
  end

  always_ff @(posedge pcau_clock_mem_i or negedge pcau_reset_i_b) begin
    if (!pcau_reset_i_b) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    upd_ok = 1'b1;
  end
`endif

  always_comb begin
    offset_ext = {{8{pcau_offset_i[7]}}, pcau_offset_i};
    pc_d       = pc_q;
    if (upd_ok) begin
      if (pcau_fsm_state_i == FsmIdle) begin
        pc_d = 16'h0000;
      end else if (pcau_en_i) begin
        if (pcau_pc_direct_i) begin
          pc_d = {pcau_pc_msb_i, pcau_offset_i};
        end else begin
          // Wraps modulo 2^16; no carry is reported.
          pc_d = pc_q + offset_ext;
        end
      end
    end
  end

  always_ff @(posedge pcau_clock_mem_i or negedge pcau_reset_i_b) begin
    if (!pcau_reset_i_b) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pcau_pc_o = pc_q;

endmodule

// File: tb/tb_core_pcau.sv
// Self-checking bench for core_pcau: per-edge reference model plus directed literal checks.
// Works with or without PCAU_PHASE_GATE_EN defined.
module tb_core_pcau;

  logic        clk;
  logic        rst_n;
  logic [7:0]  offset;
  logic        en;
  logic        direct;
  logic [7:0]  msb;
  logic [2:0]  state;
  logic [15:0] pc;

  int total;
  int bad;
  bit chk_en;

`ifdef PCAU_PHASE_GATE_EN
  localparam int EdgesPerUpd = 2;
`else
  localparam int EdgesPerUpd = 1;
`endif

  core_pcau dut (
    .pcau_clock_mem_i (clk),
    .pcau_reset_i_b   (rst_n),
    .pcau_offset_i    (offset),
    .pcau_en_i        (en),
    .pcau_pc_direct_i (direct),
    .pcau_pc_msb_i    (msb),
    .pcau_fsm_state_i (state),
    .pcau_pc_o        (pc)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Reference model: count edges since reset; an edge may update the PC
  // when the gate is off, or when it is an even-numbered edge.
  logic [15:0] m_pc;
  int          m_edges;

  function automatic logic [15:0] next_pc(input logic [15:0] cur, input int edge_no);
    int sum;
    if (EdgesPerUpd == 2 && (edge_no % 2) != 0) return cur;
    if (state == 3'd0) return 16'h0000;
    if (!en) return cur;
    if (direct) return {msb, offset};
    sum = int'(cur) + int'($signed(offset));
    return sum[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 16'h0000;
      m_edges <= 0;
    end else begin
      m_pc    <= next_pc(m_pc, m_edges);
      m_edges <= m_edges + 1;
    end
  end

  task automatic check(input string name, input logic [15:0] want);
    total++;
    if (pc !== want) begin
      bad++;
      $display("FAIL %s: pc=%h expected=%h at %0t", name, pc, want, $time);
    end
  endtask

  // Hold inputs for n allowed updates, then return just after a falling edge.
  task automatic apply(input logic e, input logic d, input logic [7:0] m, input logic [7:0] o,
                       input logic [2:0] s, input int n);
    en = e; direct = d; msb = m; offset = o; state = s;
    repeat (n * EdgesPerUpd) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    rst_n = 1'b0; en = 1'b0; direct = 1'b0; msb = 8'h00; offset = 8'h00; state = 3'd1;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          total++;
          if (pc !== m_pc) begin
            bad++;
            $display("FAIL model: pc=%h expected=%h at %0t", pc, m_pc, $time);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_low", 16'h0000);
    #5 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_release", 16'h0000);

    apply(1'b1, 1'b0, 8'h00, 8'h01, 3'd1, 1); check("inc", 16'h0001);
    apply(1'b1, 1'b0, 8'h00, 8'hFE, 3'd1, 1); check("minus2", 16'hFFFF);
    apply(1'b1, 1'b0, 8'h00, 8'h01, 3'd1, 1); check("wrap_up", 16'h0000);
    apply(1'b1, 1'b0, 8'h00, 8'hFF, 3'd1, 1); check("wrap_down", 16'hFFFF);
    apply(1'b1, 1'b1, 8'h89, 8'hD3, 3'd1, 1); check("direct", 16'h89D3);
    apply(1'b0, 1'b1, 8'h00, 8'h00, 3'd1, 4); check("hold", 16'h89D3);
    apply(1'b1, 1'b1, 8'h10, 8'h10, 3'd1, 1); check("direct2", 16'h1010);
    apply(1'b1, 1'b1, 8'h55, 8'h55, 3'd0, 1); check("idle_clear", 16'h0000);
    apply(1'b1, 1'b1, 8'h12, 8'h34, 3'd1, 1); check("direct3", 16'h1234);
    apply(1'b1, 1'b0, 8'h00, 8'h80, 3'd1, 1); check("minus128", 16'h11B4);
    apply(1'b1, 1'b0, 8'h00, 8'h7F, 3'd1, 1); check("plus127", 16'h1233);

    // Asynchronous reset pulse entirely between two clock edges.
    en = 1'b1; direct = 1'b0; offset = 8'h01; state = 3'd1;
    #5 rst_n = 1'b0;
    #5 check("reset_pulse", 16'h0000);
    #5 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_inc", 16'h0001);
    if (EdgesPerUpd == 2) begin
      @(posedge clk);
      @(negedge clk);
    end

    // Two raw memory edges with increment: one update when gated, two otherwise.
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef PCAU_PHASE_GATE_EN
    check("two_edges", 16'h0002);
`else
    check("two_edges", 16'h0003);
`endif

    // Inputs change on every edge so phase-1 samples must be ignored when gated.
    for (int i = 0; i < 40; i++) begin
      en     = 1'($urandom_range(0, 1));
      direct = 1'($urandom_range(0, 1));
      msb    = 8'($urandom);
      offset = 8'($urandom);
      state  = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
